// File: rtl/boot_loader_if.sv
// Boot loader signal bundle: byte stream in, memory write port, pc load and core control out.
// master = the loader, slave = the stream source / memory / core side.
interface boot_loader_if;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DIN;
    logic        MEM_WE;
    logic        BUS_OWN;
    logic        CPU_R;
    logic [7:0]  PC_LO;
    logic [7:0]  PC_HI;
    logic        PC_WR;
    logic        DONE;
    logic        ERR;

    modport master (
        input  RX_DATA, RX_VALID,
        output RX_READY, MEM_ADDR, MEM_DIN, MEM_WE, BUS_OWN, CPU_R,
               PC_LO, PC_HI, PC_WR, DONE, ERR
    );

    modport slave (
        output RX_DATA, RX_VALID,
        input  RX_READY, MEM_ADDR, MEM_DIN, MEM_WE, BUS_OWN, CPU_R,
               PC_LO, PC_HI, PC_WR, DONE, ERR
    );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream boot loader: writes the image to memory, loads pc, then releases the core.
// Define BOOT_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module boot_loader #(
    parameter logic [15:0] IDLE_TIMEOUT = 16'd50000
) (
    input  logic          CLK,
    input  logic          R_N,
    boot_loader_if.master bus
);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_HDR     = 3'd1,
        S_DATA    = 3'd2,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_LOAD_PC = 3'd4,
        S_RUN     = 3'd5
    } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_FRAME_END = S_CHECK;
`else
    localparam state_t S_FRAME_END = S_LOAD_PC;
`endif

    state_t      state_reg, state_next;

    logic        rx_ready_reg;
    logic [15:0] mem_addr_reg;
    logic [7:0]  mem_din_reg;
    logic        mem_we_reg;
    logic        bus_own_reg;
    logic        cpu_r_reg;
    logic [7:0]  pc_lo_reg;
    logic [7:0]  pc_hi_reg;
    logic        pc_wr_reg;
    logic        done_reg;
    logic        err_reg;

    // Header bytes in arrival order: load lo/hi, length lo/hi, start lo/hi
    logic [7:0]  hdr_reg [6];
    logic [2:0]  hdr_idx_reg;
    logic [15:0] ptr_reg;
    logic [15:0] rem_reg;
    logic [15:0] idle_cnt_reg;
    logic [7:0]  csum_reg;

    logic        xfer;
    logic        in_frame;
    logic        timeout;
    logic        cks_bad;

    assign xfer = bus.RX_VALID && rx_ready_reg;

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) state_reg <= S_SYNC;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_frame   = 1'b0;
        timeout    = 1'b0;
        cks_bad    = 1'b0;
        case (state_reg)
            S_SYNC: begin
                if (xfer && bus.RX_DATA == SYNC_BYTE) state_next = S_HDR;
            end
            S_HDR: begin
                in_frame = 1'b1;
                if (xfer && hdr_idx_reg == 3'd5)
                    state_next = ({hdr_reg[3], hdr_reg[2]} == 16'd0) ? S_FRAME_END : S_DATA;
            end
            S_DATA: begin
                in_frame = 1'b1;
                if (xfer && rem_reg == 16'd1) state_next = S_FRAME_END;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_frame = 1'b1;
                if (xfer) begin
                    if (bus.RX_DATA == csum_reg) begin
                        state_next = S_LOAD_PC;
                    end else begin
                        cks_bad    = 1'b1;
                        state_next = S_SYNC;
                    end
                end
            end
`endif
            S_LOAD_PC: state_next = S_RUN;
            S_RUN:     state_next = S_RUN;
            default:   state_next = S_SYNC;
        endcase
        // An accepted byte on the terminal-count cycle keeps the frame alive
        if (in_frame && !xfer && idle_cnt_reg == IDLE_TIMEOUT - 16'd1) begin
            timeout    = 1'b1;
            state_next = S_SYNC;
        end
    end

    // Core-side outputs follow state_reg, so PC_WR lands the cycle after the final write
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            rx_ready_reg <= 1'b0;
            mem_addr_reg <= 16'd0;
            mem_din_reg  <= 8'd0;
            mem_we_reg   <= 1'b0;
            bus_own_reg  <= 1'b1;
            cpu_r_reg    <= 1'b1;
            pc_lo_reg    <= 8'd0;
            pc_hi_reg    <= 8'd0;
            pc_wr_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            hdr_idx_reg  <= 3'd0;
            ptr_reg      <= 16'd0;
            rem_reg      <= 16'd0;
            idle_cnt_reg <= 16'd0;
            csum_reg     <= 8'd0;
            for (int i = 0; i < 6; i++) hdr_reg[i] <= 8'd0;
        end else begin
            rx_ready_reg <= (state_next != S_LOAD_PC) && (state_next != S_RUN);
            mem_we_reg   <= 1'b0;
            pc_wr_reg    <= (state_reg == S_LOAD_PC);
            cpu_r_reg    <= (state_reg != S_RUN);
            bus_own_reg  <= (state_reg != S_RUN);
            done_reg     <= done_reg | (state_reg == S_RUN);
            idle_cnt_reg <= (in_frame && !xfer && !timeout) ? idle_cnt_reg + 16'd1 : 16'd0;
            if (timeout || cks_bad) err_reg <= 1'b1;
            if (state_reg == S_LOAD_PC) begin
                pc_lo_reg <= hdr_reg[4];
                pc_hi_reg <= hdr_reg[5];
            end
            if (xfer) begin
                case (state_reg)
                    S_SYNC: begin
                        if (bus.RX_DATA == SYNC_BYTE) begin
                            err_reg     <= 1'b0;
                            hdr_idx_reg <= 3'd0;
                            csum_reg    <= 8'd0;
                        end
                    end
                    S_HDR: begin
                        hdr_reg[hdr_idx_reg] <= bus.RX_DATA;
                        hdr_idx_reg          <= hdr_idx_reg + 3'd1;
                        csum_reg             <= csum_reg ^ bus.RX_DATA;
                        if (hdr_idx_reg == 3'd5) begin
                            ptr_reg <= {hdr_reg[1], hdr_reg[0]};
                            rem_reg <= {hdr_reg[3], hdr_reg[2]};
                        end
                    end
                    S_DATA: begin
                        mem_we_reg   <= 1'b1;
                        mem_addr_reg <= ptr_reg;
                        mem_din_reg  <= bus.RX_DATA;
                        ptr_reg      <= ptr_reg + 16'd1;
                        rem_reg      <= rem_reg - 16'd1;
                        csum_reg     <= csum_reg ^ bus.RX_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.RX_READY = rx_ready_reg;
    assign bus.MEM_ADDR = mem_addr_reg;
    assign bus.MEM_DIN  = mem_din_reg;
    assign bus.MEM_WE   = mem_we_reg;
    assign bus.BUS_OWN  = bus_own_reg;
    assign bus.CPU_R    = cpu_r_reg;
    assign bus.PC_LO    = pc_lo_reg;
    assign bus.PC_HI    = pc_hi_reg;
    assign bus.PC_WR    = pc_wr_reg;
    assign bus.DONE     = done_reg;
    assign bus.ERR      = err_reg;
endmodule

// File: tb/tb_boot_loader.sv
// Table-driven bench for boot_loader: per-cycle {stimulus, expected outputs} vectors plus
// hand-written reset/timeout sequences. Honours BOOT_LOADER_CHECKSUM_EN like the design.
module tb_boot_loader;
    localparam logic [15:0] T = 16'd20;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        pcwr;
        logic [15:0] pc;
        logic        run;
        logic        err;
    } vec_t;

    logic CLK;
    logic R_N;
    boot_loader_if bus();

    boot_loader #(.IDLE_TIMEOUT(T)) dut (
        .CLK (CLK),
        .R_N (R_N),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    vec_t       vecs[$];
    int         tests  = 0;
    int         failed = 0;
    int         cur_idx = 0;
    logic [7:0] csum;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %0b, expected %0b", name, cur_idx, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %02h, expected %02h", name, cur_idx, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %04h, expected %04h", name, cur_idx, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic rdy,
                                input logic we, input logic [15:0] addr, input logic [7:0] din,
                                input logic pcwr, input logic [15:0] pc, input logic run,
                                input logic err);
        vec_t x;
        x.v = v; x.d = d; x.rdy = rdy; x.we = we; x.addr = addr; x.din = din;
        x.pcwr = pcwr; x.pc = pc; x.run = run; x.err = err;
        vecs.push_back(x);
    endfunction

    function automatic void idle(input logic rdy, input logic [15:0] pc, input logic err);
        add(1'b0, 8'h00, rdy, 1'b0, 16'h0000, 8'h00, 1'b0, pc, 1'b0, err);
    endfunction

    function automatic void add_sync_hdr(input logic [15:0] load, input logic [15:0] n,
                                         input logic [15:0] start, input int gap);
        logic [7:0] hb [6];
        hb[0] = load[7:0];  hb[1] = load[15:8];
        hb[2] = n[7:0];     hb[3] = n[15:8];
        hb[4] = start[7:0]; hb[5] = start[15:8];
        csum = 8'h00;
        add(1'b1, 8'hA5, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < gap; i++) idle(1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            csum = csum ^ hb[i];
            add(1'b1, hb[i], !(i == 5 && n == 16'd0 && !CKS_EN), 1'b0, 16'h0, 8'h0,
                1'b0, 16'h0, 1'b0, 1'b0);
        end
    endfunction

    function automatic void add_data(input logic [15:0] load, input int idx,
                                     input logic [15:0] n, input logic [7:0] b);
        csum = csum ^ b;
        add(1'b1, b, !(16'(idx) == n - 16'd1 && !CKS_EN), 1'b1, load + 16'(idx), b,
            1'b0, 16'h0, 1'b0, 1'b0);
    endfunction

    // delta != 0 corrupts the checksum byte (only meaningful with the checksum build)
    function automatic void add_tail(input logic [15:0] start, input logic [7:0] delta);
        if (CKS_EN)
            add(1'b1, csum ^ delta, delta != 8'h00, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0,
                1'b0, delta != 8'h00);
        if (delta == 8'h00) begin
            add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, start, 1'b0, 1'b0);
            add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, start, 1'b1, 1'b0);
            add(1'b1, 8'h55, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, start, 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < 3; i++) idle(1'b1, 16'h0, 1'b1);
        end
    endfunction

    function automatic void add_frame_a();
        add_sync_hdr(16'h0200, 16'd3, 16'h0200, 0);
        add_data(16'h0200, 0, 16'd3, 8'h11);
        add_data(16'h0200, 1, 16'd3, 8'h22);
        add_data(16'h0200, 2, 16'd3, 8'h33);
    endfunction

    task automatic run_vecs();
        foreach (vecs[i]) begin
            cur_idx = i;
            bus.RX_VALID = vecs[i].v;
            bus.RX_DATA  = vecs[i].d;
            @(posedge CLK);
            #1;
            chk1("rx_ready", bus.RX_READY, vecs[i].rdy);
            chk1("mem_we", bus.MEM_WE, vecs[i].we);
            if (vecs[i].we) begin
                chk16("mem_addr", bus.MEM_ADDR, vecs[i].addr);
                chk8("mem_din", bus.MEM_DIN, vecs[i].din);
            end
            chk1("pc_wr", bus.PC_WR, vecs[i].pcwr);
            chk16("pc", {bus.PC_HI, bus.PC_LO}, vecs[i].pc);
            chk1("cpu_r", bus.CPU_R, !vecs[i].run);
            chk1("bus_own", bus.BUS_OWN, !vecs[i].run);
            chk1("done", bus.DONE, vecs[i].run);
            chk1("err", bus.ERR, vecs[i].err);
            $display("[TB] vec %0d valid=%0b data=%02h -> rdy=%0b we=%0b addr=%04h din=%02h pc_wr=%0b err=%0b",
                     i, vecs[i].v, vecs[i].d, bus.RX_READY, bus.MEM_WE, bus.MEM_ADDR,
                     bus.MEM_DIN, bus.PC_WR, bus.ERR);
        end
        bus.RX_VALID = 1'b0;
        vecs.delete();
    endtask

    task automatic check_reset(input string tag);
        $display("[TB] reset check: %s", tag);
        chk1("rst_rx_ready", bus.RX_READY, 1'b0);
        chk16("rst_mem_addr", bus.MEM_ADDR, 16'h0000);
        chk8("rst_mem_din", bus.MEM_DIN, 8'h00);
        chk1("rst_mem_we", bus.MEM_WE, 1'b0);
        chk1("rst_bus_own", bus.BUS_OWN, 1'b1);
        chk1("rst_cpu_r", bus.CPU_R, 1'b1);
        chk8("rst_pc_lo", bus.PC_LO, 8'h00);
        chk8("rst_pc_hi", bus.PC_HI, 8'h00);
        chk1("rst_pc_wr", bus.PC_WR, 1'b0);
        chk1("rst_done", bus.DONE, 1'b0);
        chk1("rst_err", bus.ERR, 1'b0);
    endtask

    task automatic do_reset();
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        R_N = 1'b0;
        @(posedge CLK);
        #1;
        check_reset("power-on");
        R_N = 1'b1;
    endtask

    initial begin
        CLK = 1'b0;
        R_N = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;

        // Back-to-back frame; first idle vector checks RX_READY rises after reset release
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add_frame_a();
        add_tail(16'h0200, 8'h00);
        run_vecs();

        // Junk before sync is swallowed without writes
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add(1'b1, 8'h00, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        add(1'b1, 8'h5A, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        add_frame_a();
        add_tail(16'h0200, 8'h00);
        run_vecs();

        // Write pointer wraps 0xFFFF -> 0x0000
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add_sync_hdr(16'hFFFF, 16'd2, 16'h1234, 0);
        add_data(16'hFFFF, 0, 16'd2, 8'hAB);
        add_data(16'hFFFF, 1, 16'd2, 8'hCD);
        add_tail(16'h1234, 8'h00);
        run_vecs();

        // Empty image: straight to pc load
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add_sync_hdr(16'h0300, 16'd0, 16'hBEEF, 0);
        add_tail(16'hBEEF, 8'h00);
        run_vecs();

        // Idle timeout after two header bytes, then a clean frame clears ERR
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        add(1'b1, 8'h00, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        add(1'b1, 8'h02, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < int'(T) - 1; i++) idle(1'b1, 16'h0, 1'b0);
        idle(1'b1, 16'h0, 1'b1);
        idle(1'b1, 16'h0, 1'b1);
        add_sync_hdr(16'h0040, 16'd1, 16'h0040, 0);
        add_data(16'h0040, 0, 16'd1, 8'h99);
        add_tail(16'h0040, 8'h00);
        run_vecs();

        // A byte landing on the terminal-count cycle is accepted, no abort
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add_sync_hdr(16'h0010, 16'd1, 16'h0010, int'(T) - 1);
        add_data(16'h0010, 0, 16'd1, 8'h5A);
        add_tail(16'h0010, 8'h00);
        run_vecs();

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Corrupted checksum (04 instead of 03): ERR, core held in reset
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add_frame_a();
        add_tail(16'h0200, 8'h07);
        run_vecs();
`endif

        // Asynchronous reset in the middle of DATA while a write is on the bus
        do_reset();
        idle(1'b1, 16'h0, 1'b0);
        add_sync_hdr(16'h0300, 16'd3, 16'h0300, 0);
        add_data(16'h0300, 0, 16'd3, 8'h77);
        run_vecs();
        #1;
        R_N = 1'b0;
        #1;
        check_reset("mid-data");
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream boot loader sitting directly upstream of the 6502 core and its MEMORY. Out of reset it owns the memory bus and holds the core in reset. It receives a framed program image over a valid/ready byte interface, writes the image into memory, and loads the program counter with the frame's start address. It then hands the bus to the core and releases the core's reset.

## Interface
Parameters:
- IDLE_TIMEOUT, 16'd50000: cycles without an accepted byte, mid-frame, before the frame is aborted.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- R_N  in  1  reset, asynchronous, active-low.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA is valid.
- RX_READY  out  1  loader accepts a byte; a transfer occurs on a rising edge with RX_VALID && RX_READY.
- MEM_ADDR  out  16  memory address while the loader owns the bus.
- MEM_DIN  out  8  write data to MEMORY.DataIn.
- MEM_WE  out  1  memory write enable.
- BUS_OWN  out  1  bus mux select: 1 = loader drives MEMORY, 0 = core drives MEMORY.
- CPU_R  out  1  active-high reset to the core's R and to pc.
- PC_LO  out  8  start address low byte, to pc LO.
- PC_HI  out  8  start address high byte, to pc HI.
- PC_WR  out  1  pc load strobe, to pc WR.
- DONE  out  1  image loaded, core running.
- ERR  out  1  last frame was aborted (timeout or checksum failure).

## Operation
- Frame format, in order:
  - sync byte 0xA5;
  - LOAD_LO, LOAD_HI;
  - LEN_LO, LEN_HI (byte count N);
  - START_LO, START_HI;
  - N data bytes;
  - one checksum byte (only with the macro; see Configuration).
- All outputs are registered. Reset values: RX_READY=0, MEM_ADDR=0, MEM_DIN=0, MEM_WE=0, BUS_OWN=1, CPU_R=1, PC_LO=0, PC_HI=0, PC_WR=0, DONE=0, ERR=0.
- States and transitions:
  - SYNC: a byte other than 0xA5 is discarded. 0xA5 goes to HDR, clears ERR and zeroes the header index and checksum.
  - HDR: accepts 6 bytes into load address, length and start address. After the 6th byte: N=0 goes to CHECK (macro on) or LOAD_PC (macro off); otherwise goes to DATA.
  - DATA:
    - On each accepted byte: MEM_ADDR<=ptr, MEM_DIN<=byte, MEM_WE<=1; ptr increments modulo 2^16 (0xFFFF wraps to 0x0000); remaining count decrements.
    - MEM_WE is 0 on every cycle with no transfer.
    - After byte N: goes to CHECK (macro on) or LOAD_PC (macro off).
  - CHECK: accepts one byte.
    - Equal to the running XOR: goes to LOAD_PC.
    - Otherwise: ERR<=1 and goes to SYNC.
  - LOAD_PC: for one cycle, PC_LO/PC_HI=start address, PC_WR=1, CPU_R=1, RX_READY=0. Then goes to RUN.
  - RUN: CPU_R=0, BUS_OWN=0, DONE=1, RX_READY=0, MEM_WE=0. Terminal until reset.
- RX_READY is 1 in SYNC, HDR, DATA and CHECK, and 0 otherwise.
- Timeout:
  - In HDR, DATA and CHECK, a 16-bit counter counts cycles without a transfer and clears on each transfer.
  - On reaching IDLE_TIMEOUT: ERR<=1, MEM_WE<=0, goes to SYNC.
  - Bytes already written stay in memory.
- Simultaneous events: if a transfer and the timeout terminal count coincide, the transfer wins and the counter clears.
- ERR stays set until the next accepted 0xA5. DONE is cleared only by reset.
- Reset mid-operation (R_N low in any state): all outputs return to their reset values immediately and the partial frame is abandoned.

## Timing
- Byte accepted at edge t → MEM_WE/MEM_ADDR/MEM_DIN valid from t to t+1. Sustains one byte per cycle with no bubbles.
- Last write cycle (MEM_WE=1) always precedes the LOAD_PC cycle, so BUS_OWN never drops during a write.
- LOAD_PC is exactly one cycle. CPU_R falls and BUS_OWN falls on the same edge one cycle after PC_WR.
- RX_READY rises on the first edge after R_N deasserts.

## Configuration
- BOOT_LOADER_CHECKSUM_EN defined:
  - The CHECK state and the trailing checksum byte exist.
  - The checksum is the XOR of the 6 header bytes and all data bytes.
  - A mismatch sets ERR and returns to SYNC; the core stays in reset.
- Not defined:
  - No checksum byte is expected and the CHECK state is absent.
  - The frame ends after the last data byte (or after the header when N=0).

## Test plan
- Back-to-back frame A5 00 02 03 00 00 02 11 22 33 [03] → MEM_WE on 3 consecutive cycles writing 0x0200=11, 0x0201=22, 0x0202=33; one PC_WR with PC=0x0200; next cycle CPU_R=0, BUS_OWN=0, DONE=1.
- Bytes 00 FF 5A before the frame → no MEM_WE and no state change until 0xA5; the frame then completes as in the first test.
- Frame with LOAD=0xFFFF, N=2 → writes to 0xFFFF then 0x0000.
- Frame with N=0 → no MEM_WE; PC loaded; DONE=1.
- Stop after 2 header bytes and wait IDLE_TIMEOUT cycles → ERR=1, RX_READY=1, CPU_R=1. A following valid frame clears ERR at its 0xA5 and completes.
- Checksum 04 instead of 03 (macro on) → ERR=1, PC_WR never pulses, CPU_R=1. Separately, R_N low during DATA → all outputs at their reset values within the same cycle.
